updi_uart_tx: RTL and testbench
===============================

Name: updi_uart_tx

Overview:
Downstream consumer of the UPDI instruction byte FIFO. Pops one byte at a time and serialises it onto the UPDI single-wire line as a UPDI UART frame: 1 start bit, 8 data bits LSB first, even parity, 2 stop bits. Drives the line value and the output enable for the external half-duplex pad. Pulses a per-frame completion strobe for upstream sequencing and debug.

Parameters:
CLK_DIV, 16, clk cycles per UART bit; legal range >= 2.
DIV_BITS, $clog2(CLK_DIV), baud counter width.
BREAK_BITS, 24, BREAK low duration in bit times (used only with the optional feature).

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
fifo_data  input  8  head of FIFO (first-word-fall-through, valid whenever !fifo_empty)
fifo_empty  input  1  FIFO has no byte
fifo_rd_en  output  1  one-cycle pop strobe
tx  output  1  serial line value
tx_oe  output  1  pad drive enable; line is pulled up when low
busy  output  1  frame or BREAK in progress
frame_done  output  1  one-cycle pulse after the last stop bit of a data frame
send_break  input  1  BREAK request (present only with the optional feature)

Behaviour:
- Reset values: tx=1, tx_oe=0, busy=0, fifo_rd_en=0, frame_done=0; state=IDLE; counters=0.
- fifo_rd_en is combinational: high only in IDLE && !fifo_empty && !rst. In that same cycle fifo_data latches into the shift register, and the state moves to START.
- Frame bit order: START(0), D0..D7, PARITY = XOR(D7..D0), STOP1(1), STOP2(1). Total 12 bit times.
- Bit duration: each bit holds for exactly CLK_DIV cycles. The baud counter runs 0..CLK_DIV-1 and restarts at every state entry. Bit advance happens when count == CLK_DIV-1.
- Registered outputs: tx and tx_oe are registered. tx_oe=1 and busy=1 from the first START cycle through the last STOP2 cycle. In IDLE, tx=1 and tx_oe=0.
- State sequence: IDLE -> START -> DATA (3-bit index 0..7) -> PARITY -> STOP (1-bit index 0..1) -> IDLE.
- frame_done: asserted for 1 cycle on the first IDLE cycle after STOP2.
- Minimum frame spacing: IDLE lasts at least 1 cycle. Back-to-back frames therefore start 12*CLK_DIV+1 cycles apart.
- Latency: first START cycle on tx is 1 cycle after the fifo_rd_en pulse.
- fifo_empty is ignored outside IDLE. No pop can occur mid-frame.
- Reset mid-frame: the next cycle shows reset values, the in-flight byte is dropped, and no frame_done is produced.
- No error or underflow conditions exist. An empty FIFO simply holds IDLE.

Optional Feature:
Macro UPDI_UART_TX_BREAK_EN.
- With the macro:
  - Adds the send_break port and the BREAK and BREAK_STOP states.
  - send_break is sampled only in IDLE and has priority over a non-empty FIFO in the same cycle; no pop occurs that cycle.
  - BREAK drives tx=0, tx_oe=1 for BREAK_BITS*CLK_DIV cycles.
  - BREAK_STOP then drives tx=1, tx_oe=1 for 2*CLK_DIV cycles, then returns to IDLE.
  - busy=1 throughout BREAK and BREAK_STOP; frame_done is not pulsed.
- Without the macro: no send_break port, no BREAK states, and the behaviour is otherwise identical.

Decomposition:
- Package updi_uart_pkg:
  - State enum updi_uart_tx_state (IDLE, START, DATA, PARITY, STOP, BREAK, BREAK_STOP).
  - Constants UPDI_UART_DATA_BITS=8, UPDI_UART_STOP_BITS=2, UPDI_UART_IDLE_LEVEL=1.
  - Shared later by the RX/ACK-detect block.
- Sub-module updi_baud_tick:
  - Parameterised by CLK_DIV.
  - Inputs: clk, rst, restart.
  - Output: bit_end, a pulse on the last cycle of each bit period.

Test Plan:
All scenarios use CLK_DIV=4.
1. FIFO holds 0x55 -> one fifo_rd_en pulse. tx per 4-cycle bit: 0,1,0,1,0,1,0,1,0,P=0,1,1. tx_oe high 48 cycles. frame_done 1 cycle after.
2. Byte 0x01 -> parity bit 1. Byte 0x00 -> parity 0, data bits all 0, stop bits 1,1.
3. FIFO preloaded with 0x55, 0x10 -> fifo_rd_en pulses exactly 49 cycles apart; second frame parity 1; two frame_done pulses.
4. fifo_empty held high for 200 cycles -> tx=1, tx_oe=0, busy=0, no fifo_rd_en.
5. rst asserted during data bit D3 of 0xA5 -> next cycle tx=1, tx_oe=0, busy=0, no frame_done. After release with the FIFO empty, the line stays idle.
6. UPDI_UART_TX_BREAK_EN defined; send_break and !fifo_empty in the same IDLE cycle -> tx=0 for 96 cycles, then tx=1 with oe for 8 cycles, then IDLE. The pop occurs on the following cycle and the frame follows.

Source files
------------

// File: rtl/updi_uart_pkg.sv
// Shared UPDI UART definitions: state encoding and frame constants.
// Used by the TX serialiser and the RX/ACK-detect block.
package updi_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK,
        BREAK_STOP
    } updi_uart_tx_state;

    localparam int unsigned UPDI_UART_DATA_BITS  = 8;
    localparam int unsigned UPDI_UART_STOP_BITS  = 2;
    localparam logic        UPDI_UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/updi_baud_tick.sv
// Bit-period timer: bit_end pulses on the last clk cycle of each CLK_DIV-cycle bit.
// restart holds the counter at zero so the next bit starts with a full period.
module updi_baud_tick #(
    parameter int unsigned CLK_DIV  = 16,
    parameter int unsigned DIV_BITS = $clog2(CLK_DIV)
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);

    logic [DIV_BITS-1:0] count_q;

    assign bit_end = (count_q == DIV_BITS'(CLK_DIV - 1));

    // Free-running 0..CLK_DIV-1 counter, cleared while idle and at each bit boundary.
    always_ff @(posedge clk) begin
        if (rst || restart || bit_end) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + DIV_BITS'(1);
        end
    end

endmodule

// File: rtl/updi_uart_tx.sv
// UPDI UART transmitter: pops bytes from a FWFT FIFO and sends 8E2 frames
// (start, D0..D7, even parity, two stop bits) on the half-duplex UPDI line.
// Optional BREAK generation is enabled with the macro UPDI_UART_TX_BREAK_EN.
module updi_uart_tx
    import updi_uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned DIV_BITS   = $clog2(CLK_DIV),
    parameter int unsigned BREAK_BITS = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       tx_oe,
    output logic       busy,
    output logic       frame_done
`ifdef UPDI_UART_TX_BREAK_EN
    ,
    input  logic       send_break
`endif
);

    // One counter serves data bits, stop bits and BREAK bit times.
    localparam int unsigned BIT_CNT_W =
        (BREAK_BITS > UPDI_UART_DATA_BITS) ? $clog2(BREAK_BITS) : 3;

    updi_uart_tx_state    state_q;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [7:0]           tx_byte_q;
    logic                 parity_q;
    logic                 bit_end;

    // Counter is held cleared in IDLE so the first START bit is a full period.
    updi_baud_tick #(
        .CLK_DIV  (CLK_DIV),
        .DIV_BITS (DIV_BITS)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (state_q == IDLE),
        .bit_end (bit_end)
    );

`ifdef UPDI_UART_TX_BREAK_EN
    // BREAK request wins over a waiting byte; the byte is popped after the BREAK.
    assign fifo_rd_en = (state_q == IDLE) && !fifo_empty && !send_break && !rst;
`else
    assign fifo_rd_en = (state_q == IDLE) && !fifo_empty && !rst;
`endif

    // Frame sequencer with registered line, enable, busy and completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            tx_byte_q  <= '0;
            parity_q   <= 1'b0;
            tx         <= UPDI_UART_IDLE_LEVEL;
            tx_oe      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state_q)
                IDLE: begin
`ifdef UPDI_UART_TX_BREAK_EN
                    if (send_break) begin
                        state_q   <= BREAK;
                        bit_cnt_q <= '0;
                        tx        <= 1'b0;
                        tx_oe     <= 1'b1;
                        busy      <= 1'b1;
                    end else
`endif
                    if (fifo_rd_en) begin
                        state_q   <= START;
                        tx_byte_q <= fifo_data;
                        parity_q  <= ^fifo_data;
                        tx        <= 1'b0;
                        tx_oe     <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q   <= DATA;
                        bit_cnt_q <= '0;
                        tx        <= tx_byte_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt_q == BIT_CNT_W'(UPDI_UART_DATA_BITS - 1)) begin
                            state_q <= PARITY;
                            tx      <= parity_q;
                        end else begin
                            // LSB-first: shift so the next bit is always at [0].
                            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                            tx_byte_q <= {1'b0, tx_byte_q[7:1]};
                            tx        <= tx_byte_q[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state_q   <= STOP;
                        bit_cnt_q <= '0;
                        tx        <= UPDI_UART_IDLE_LEVEL;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (bit_cnt_q == BIT_CNT_W'(UPDI_UART_STOP_BITS - 1)) begin
                            state_q    <= IDLE;
                            tx_oe      <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end
`ifdef UPDI_UART_TX_BREAK_EN
                BREAK: begin
                    if (bit_end) begin
                        if (bit_cnt_q == BIT_CNT_W'(BREAK_BITS - 1)) begin
                            state_q   <= BREAK_STOP;
                            bit_cnt_q <= '0;
                            tx        <= UPDI_UART_IDLE_LEVEL;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end
                BREAK_STOP: begin
                    if (bit_end) begin
                        if (bit_cnt_q == BIT_CNT_W'(UPDI_UART_STOP_BITS - 1)) begin
                            state_q <= IDLE;
                            tx_oe   <= 1'b0;
                            busy    <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    tx      <= UPDI_UART_IDLE_LEVEL;
                    tx_oe   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_updi_uart_tx.sv
// Scoreboard bench for updi_uart_tx: expected frames are queued at stimulus time and
// a monitor captures every tx_oe window and compares it with a per-bit waveform model.
module tb_updi_uart_tx;

    localparam int CLK_DIV    = 4;
    localparam int BREAK_BITS = 24;

    typedef struct {
        bit         is_break;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd_en, tx, tx_oe, busy, frame_done;
`ifdef UPDI_UART_TX_BREAK_EN
    logic       send_break = 1'b0;
`endif

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    int         rd_cycles[$];
    logic       win[$];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int busy_bad = 0;
    int stray_done = 0;
    int last_rd = -10;
    int win_start = 0;
    bit in_win = 1'b0;
    bit rst_seen = 1'b0;

    updi_uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .DIV_BITS   (2),
        .BREAK_BITS (BREAK_BITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .tx_oe      (tx_oe),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef UPDI_UART_TX_BREAK_EN
        ,
        .send_break (send_break)
`endif
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check_eq(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endtask

    task automatic push_byte(input logic [7:0] b);
        exp_t e;
        e.is_break = 1'b0;
        e.data     = b;
        fifo_q.push_back(b);
        exp_q.push_back(e);
        drive_fifo();
    endtask

    // Line level expected during bit time b of a frame or BREAK.
    function automatic logic exp_bit(input exp_t e, input int b);
        if (e.is_break) return (b < BREAK_BITS) ? 1'b0 : 1'b1;
        if (b == 0) return 1'b0;
        if (b <= 8) return e.data[b-1];
        if (b == 9) return (($countones(e.data) % 2) == 1);
        return 1'b1;
    endfunction

    task automatic end_window();
        exp_t e;
        int   n_exp;
        int   first_bad;
        if (exp_q.size() == 0) begin
            check_eq("unexpected_window", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        if (rst_seen) begin
            check_eq("abort_no_frame_done", int'(frame_done), 0);
            return;
        end
        n_exp = e.is_break ? (BREAK_BITS + 2) * CLK_DIV : 12 * CLK_DIV;
        check_eq($sformatf("oe_len_%s%02h", e.is_break ? "brk" : "byte", e.data),
                 win.size(), n_exp);
        first_bad = -1;
        for (int i = 0; i < win.size() && i < n_exp; i++) begin
            if (first_bad < 0 && win[i] !== exp_bit(e, i / CLK_DIV)) first_bad = i;
        end
        check_eq($sformatf("wave_first_bad_cycle_%s%02h", e.is_break ? "brk" : "byte",
                 e.data), first_bad, -1);
        check_eq("frame_done_after_window", int'(frame_done), e.is_break ? 0 : 1);
        check_eq("tx_idle_after_window", int'(tx), 1);
    endtask

    // Pops the FIFO model after the edge on which the DUT latched the head byte.
    initial forever begin
        bit pop_pend;
        @(negedge clk);
        pop_pend = (fifo_rd_en === 1'b1);
        @(posedge clk);
        #1;
        if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
        drive_fifo();
    end

    // Monitor: capture each tx_oe window, score it on the first cycle after it closes.
    initial forever begin
        @(negedge clk);
        if (tx_oe === 1'b1) begin
            if (!in_win) begin
                in_win    = 1'b1;
                rst_seen  = 1'b0;
                win_start = cyc;
                win.delete();
                if (exp_q.size() > 0 && !exp_q[0].is_break)
                    check_eq("start_latency_after_pop", win_start - last_rd, 1);
            end
            win.push_back(tx);
            if (busy !== 1'b1) busy_bad++;
            if (frame_done !== 1'b0) stray_done++;
            if (rst === 1'b1) rst_seen = 1'b1;
        end else if (in_win) begin
            in_win = 1'b0;
            end_window();
        end else if (frame_done !== 1'b0) begin
            stray_done++;
        end
        if (fifo_rd_en === 1'b1) begin
            if (in_win) check_eq("pop_mid_frame", 1, 0);
            rd_cycles.push_back(cyc);
            last_rd = cyc;
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_win || fifo_q.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check_eq({"complete_", name}, int'(n < 3000), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int n, input string name);
        int bad;
        bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_oe !== 1'b0 || busy !== 1'b0 || fifo_rd_en !== 1'b0) bad++;
        end
        check_eq({"idle_bad_cycles_", name}, bad, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        // Byte waiting during reset: must not be popped until reset releases.
        push_byte(8'h55);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_tx", int'(tx), 1);
        check_eq("reset_tx_oe", int'(tx_oe), 0);
        check_eq("reset_busy", int'(busy), 0);
        check_eq("reset_frame_done", int'(frame_done), 0);
        check_eq("reset_rd_en", int'(fifo_rd_en), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_idle("0x55");

        push_byte(8'h01);
        wait_idle("0x01");
        push_byte(8'h00);
        wait_idle("0x00");

        // Back-to-back frames: pops exactly 12*CLK_DIV+1 cycles apart.
        rd_cycles.delete();
        push_byte(8'h55);
        push_byte(8'h10);
        wait_idle("b2b");
        check_eq("b2b_pop_count", rd_cycles.size(), 2);
        if (rd_cycles.size() == 2)
            check_eq("b2b_pop_spacing", rd_cycles[1] - rd_cycles[0], 12 * CLK_DIV + 1);

        check_idle(200, "empty_fifo");

        // Reset during D3 of 0xA5 (window cycles 16..19).
        push_byte(8'hA5);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (fifo_rd_en === 1'b1) found = 1'b1;
        end
        check_eq("a5_popped", int'(found), 1);
        if (found) begin
            @(posedge clk);
            repeat (17) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1;
            check_eq("midreset_tx", int'(tx), 1);
            check_eq("midreset_tx_oe", int'(tx_oe), 0);
            check_eq("midreset_busy", int'(busy), 0);
        end
        rst = 1'b0;
        check_idle(20, "after_reset");
        check_eq("after_reset_exp_empty", exp_q.size(), 0);

        // Random bytes with random gaps, sometimes two queued at once.
        for (int i = 0; i < 10; i++) begin
            push_byte(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) == 0) push_byte(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 60)) @(posedge clk);
            #1;
        end
        wait_idle("random");

`ifdef UPDI_UART_TX_BREAK_EN
        begin
            exp_t eb;
            eb.is_break = 1'b1;
            eb.data     = 8'h00;
            exp_q.push_back(eb);
            send_break = 1'b1;
            push_byte(8'h3C);
            @(negedge clk);
            check_eq("break_priority_no_pop", int'(fifo_rd_en), 0);
            @(posedge clk);
            #1 send_break = 1'b0;
            wait_idle("break_then_frame");
        end
`endif

        check_eq("busy_low_inside_window", busy_bad, 0);
        check_eq("stray_frame_done", stray_done, 0);
        check_eq("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
